// File: rtl/cordic_pkg.sv
// ============================================================================
// Module   : cordic_pkg
// Purpose  : Shared Q2.10 constants, word type and atan table for the CORDIC
//            sine/cosine engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

  localparam int CORDIC_W         = 12;
  localparam int CORDIC_FRAC      = 10;
  localparam int CORDIC_KN        = 622;
  localparam int CORDIC_STEPS     = 11;
  localparam int CORDIC_KN_STAGES = 4;

  typedef logic signed [CORDIC_W-1:0] cordic_word_t;

  // atan(2^-i) in Q2.10, i = 0..10
  function automatic cordic_word_t cordic_atan(input int step);
    cordic_word_t v;
    case (step)
      0:       v = cordic_word_t'(804);
      1:       v = cordic_word_t'(475);
      2:       v = cordic_word_t'(251);
      3:       v = cordic_word_t'(127);
      4:       v = cordic_word_t'(64);
      5:       v = cordic_word_t'(32);
      6:       v = cordic_word_t'(16);
      7:       v = cordic_word_t'(8);
      8:       v = cordic_word_t'(4);
      9:       v = cordic_word_t'(2);
      10:      v = cordic_word_t'(1);
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cordic_step_kn_if.sv
// ============================================================================
// Module   : cordic_step_kn_if
// Purpose  : Data bundle carried between CORDIC stages (vector, angle, target).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_step_kn_if
  import cordic_pkg::*;
#(
  parameter int W = CORDIC_W
);
  logic signed [W-1:0] sin_in;
  logic signed [W-1:0] cos_in;
  logic signed [W-1:0] angle_in;
  logic signed [W-1:0] t_angle_in;
  logic signed [W-1:0] atan;
  logic signed [W-1:0] sin_out;
  logic signed [W-1:0] cos_out;
  logic signed [W-1:0] angle_out;
  logic signed [W-1:0] t_angle_out;

  modport master (
    output sin_in, cos_in, angle_in, t_angle_in, atan,
    input  sin_out, cos_out, angle_out, t_angle_out
  );

  modport slave (
    input  sin_in, cos_in, angle_in, t_angle_in, atan,
    output sin_out, cos_out, angle_out, t_angle_out
  );
endinterface

`default_nettype wire

// File: rtl/kn_mul.sv
// ============================================================================
// Module   : kn_mul
// Purpose  : 4-stage Kn gain pipeline for one channel: input, product,
//            shift, saturate. Macro CORDIC_KN_ROUND_EN selects half-up rounding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kn_mul
  import cordic_pkg::*;
#(
  parameter int W    = CORDIC_W,
  parameter int KN   = CORDIC_KN,
  parameter int FRAC = CORDIC_FRAC
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ce,
  input  logic signed [W-1:0] x,
  output logic signed [W-1:0] y
);

  localparam int PW = 2 * W;
  localparam logic signed [PW-1:0] KN_EXT  = PW'(KN);
  localparam logic signed [PW-1:0] SAT_MAX = PW'((1 << (W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-(1 << (W - 1)));
`ifdef CORDIC_KN_ROUND_EN
  localparam logic signed [PW-1:0] RND     = PW'(1 << (FRAC - 1));
`else
  localparam logic signed [PW-1:0] RND     = '0;
`endif

  logic signed [W-1:0]  r_x;
  logic signed [PW-1:0] r_p;
  logic signed [PW-1:0] r_r;
  logic signed [W-1:0]  r_y;

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;
  logic signed [W-1:0]  w_sat;

  assign w_prod  = PW'(r_x) * KN_EXT;
  assign w_shift = (r_p + RND) >>> FRAC;

  always_comb begin
    w_sat = r_r[W-1:0];
    if (r_r > SAT_MAX) begin
      w_sat = SAT_MAX[W-1:0];
    end else if (r_r < SAT_MIN) begin
      w_sat = SAT_MIN[W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_p <= '0;
      r_r <= '0;
      r_y <= '0;
    end else if (ce) begin
      r_x <= x;
      r_p <= w_prod;
      r_r <= w_shift;
      r_y <= w_sat;
    end
  end

  assign y = r_y;

endmodule

`default_nettype wire

// File: rtl/cordic_step_kn.sv
// ============================================================================
// Module   : cordic_step_kn
// Purpose  : One rotation-mode CORDIC micro-rotation; with SCALE=1 appends the
//            Kn gain pipeline (rounding via macro CORDIC_KN_ROUND_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_step_kn
  import cordic_pkg::*;
#(
  parameter int W     = CORDIC_W,
  parameter int STEP  = 0,
  parameter int SCALE = 0,
  parameter int KN    = CORDIC_KN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  cordic_step_kn_if.slave  bus
);

  logic signed [W-1:0] w_sin;
  logic signed [W-1:0] w_cos;
  logic signed [W-1:0] w_sin_sh;
  logic signed [W-1:0] w_cos_sh;
  logic                w_dir_pos;
  logic signed [W-1:0] w_cos_nxt;
  logic signed [W-1:0] w_sin_nxt;
  logic signed [W-1:0] w_ang_nxt;

  logic signed [W-1:0] r_cos;
  logic signed [W-1:0] r_sin;
  logic signed [W-1:0] r_ang;
  logic signed [W-1:0] r_tang;

  assign w_sin     = $signed(bus.sin_in);
  assign w_cos     = $signed(bus.cos_in);
  assign w_sin_sh  = w_sin >>> STEP;
  assign w_cos_sh  = w_cos >>> STEP;
  // Equality rotates clockwise so a converged angle keeps oscillating symmetrically
  assign w_dir_pos = $signed(bus.angle_in) < $signed(bus.t_angle_in);

  assign w_cos_nxt = w_dir_pos ? (w_cos - w_sin_sh) : (w_cos + w_sin_sh);
  assign w_sin_nxt = w_dir_pos ? (w_sin + w_cos_sh) : (w_sin - w_cos_sh);
  assign w_ang_nxt = w_dir_pos ? ($signed(bus.angle_in) + $signed(bus.atan))
                               : ($signed(bus.angle_in) - $signed(bus.atan));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cos  <= '0;
      r_sin  <= '0;
      r_ang  <= '0;
      r_tang <= '0;
    end else if (ce) begin
      r_cos  <= w_cos_nxt;
      r_sin  <= w_sin_nxt;
      r_ang  <= w_ang_nxt;
      r_tang <= bus.t_angle_in;
    end
  end

  generate
    if (SCALE != 0) begin : g_scale
      logic signed [W-1:0] r_ang_dly  [CORDIC_KN_STAGES];
      logic signed [W-1:0] r_tang_dly [CORDIC_KN_STAGES];

      kn_mul #(.W(W), .KN(KN), .FRAC(CORDIC_FRAC)) u_kn_sin (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .x     (r_sin),
        .y     (bus.sin_out)
      );

      kn_mul #(.W(W), .KN(KN), .FRAC(CORDIC_FRAC)) u_kn_cos (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .x     (r_cos),
        .y     (bus.cos_out)
      );

      // Angles ride a matching delay line so they stay aligned with sin/cos
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < CORDIC_KN_STAGES; i++) begin
            r_ang_dly[i]  <= '0;
            r_tang_dly[i] <= '0;
          end
        end else if (ce) begin
          r_ang_dly[0]  <= r_ang;
          r_tang_dly[0] <= r_tang;
          for (int i = 1; i < CORDIC_KN_STAGES; i++) begin
            r_ang_dly[i]  <= r_ang_dly[i-1];
            r_tang_dly[i] <= r_tang_dly[i-1];
          end
        end
      end

      assign bus.angle_out   = r_ang_dly[CORDIC_KN_STAGES-1];
      assign bus.t_angle_out = r_tang_dly[CORDIC_KN_STAGES-1];
    end else begin : g_noscale
      assign bus.sin_out     = r_sin;
      assign bus.cos_out     = r_cos;
      assign bus.angle_out   = r_ang;
      assign bus.t_angle_out = r_tang;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cordic_step_kn.sv
// ============================================================================
// Module   : tb_cordic_step_kn
// Purpose  : Directed self-checking bench for cordic_step_kn (SCALE=0 and 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_step_kn;
  import cordic_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ce    = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  cordic_step_kn_if #(.W(CORDIC_W)) bus_s0 ();
  cordic_step_kn_if #(.W(CORDIC_W)) bus_s1 ();
  cordic_step_kn_if #(.W(CORDIC_W)) bus_s2 ();
  cordic_step_kn_if #(.W(CORDIC_W)) bus_sc ();

  cordic_step_kn #(.W(CORDIC_W), .STEP(0), .SCALE(0), .KN(CORDIC_KN)) u_s0 (
    .clock(clock), .reset(reset), .ce(ce), .bus(bus_s0));
  cordic_step_kn #(.W(CORDIC_W), .STEP(1), .SCALE(0), .KN(CORDIC_KN)) u_s1 (
    .clock(clock), .reset(reset), .ce(ce), .bus(bus_s1));
  cordic_step_kn #(.W(CORDIC_W), .STEP(2), .SCALE(0), .KN(CORDIC_KN)) u_s2 (
    .clock(clock), .reset(reset), .ce(ce), .bus(bus_s2));
  cordic_step_kn #(.W(CORDIC_W), .STEP(10), .SCALE(1), .KN(CORDIC_KN)) u_sc (
    .clock(clock), .reset(reset), .ce(ce), .bus(bus_sc));

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  int exp_sin_sc;

  initial begin
`ifdef CORDIC_KN_ROUND_EN
    exp_sin_sc = -607;
`else
    exp_sin_sc = -608;
`endif

    bus_s0.sin_in = 0;    bus_s0.cos_in = 1024; bus_s0.angle_in = 0;
    bus_s0.t_angle_in = 804; bus_s0.atan = cordic_atan(0);
    bus_s1.sin_in = 1024; bus_s1.cos_in = 1024; bus_s1.angle_in = 804;
    bus_s1.t_angle_in = 0;   bus_s1.atan = cordic_atan(1);
    bus_s2.sin_in = -5;   bus_s2.cos_in = 0;    bus_s2.angle_in = 100;
    bus_s2.t_angle_in = 100; bus_s2.atan = cordic_atan(2);
    bus_sc.sin_in = -1001; bus_sc.cos_in = 1685; bus_sc.angle_in = 0;
    bus_sc.t_angle_in = 1;   bus_sc.atan = cordic_atan(10);
    ce = 1'b1;

    // Reset held across an edge: everything stays at zero
    tick();
    chk("rst_s0_cos", int'(bus_s0.cos_out), 0);
    chk("rst_sc_sin", int'(bus_sc.sin_out), 0);
    chk("rst_sc_cos", int'(bus_sc.cos_out), 0);
    chk("rst_sc_ang", int'(bus_sc.angle_out), 0);
    chk("rst_sc_tang", int'(bus_sc.t_angle_out), 0);

    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("s0_cos", int'(bus_s0.cos_out), 1024);
    chk("s0_sin", int'(bus_s0.sin_out), 1024);
    chk("s0_ang", int'(bus_s0.angle_out), 804);
    chk("s0_tang", int'(bus_s0.t_angle_out), 804);
    chk("s1_cos", int'(bus_s1.cos_out), 1536);
    chk("s1_sin", int'(bus_s1.sin_out), 512);
    chk("s1_ang", int'(bus_s1.angle_out), 329);
    chk("s2_cos", int'(bus_s2.cos_out), -2);
    chk("s2_sin", int'(bus_s2.sin_out), -5);
    chk("s2_ang", int'(bus_s2.angle_out), -151);

    // Scaled stage: nothing after 4 edges, result on the 5th
    tick(); tick(); tick();
    chk("sc_lat4_cos", int'(bus_sc.cos_out), 0);
    tick();
    chk("sc_cos", int'(bus_sc.cos_out), 1024);
    chk("sc_sin", int'(bus_sc.sin_out), exp_sin_sc);
    chk("sc_ang", int'(bus_sc.angle_out), 1);
    chk("sc_tang", int'(bus_sc.t_angle_out), 1);

    // ce low: all stages hold even with new input
    ce = 1'b0;
    bus_sc.cos_in = 0;
    bus_sc.sin_in = 0;
    tick(); tick();
    chk("hold_cos", int'(bus_sc.cos_out), 1024);
    chk("hold_sin", int'(bus_sc.sin_out), exp_sin_sc);

    // Fresh pipeline, then stream with ce alternating 1,0,1,0...
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus_sc.sin_in = 0;
    bus_sc.cos_in = 1024;
    bus_sc.t_angle_in = 2047;
    bus_sc.atan = 1;
    for (int i = 0; i <= 10; i++) begin
      ce = (i % 2 == 0);
      bus_sc.angle_in = 12'(100 + 10 * (i / 2));
      tick();
      if (i == 6) chk("str_e4_ang", int'(bus_sc.angle_out), 0);
      if (i == 7) chk("str_off_ang", int'(bus_sc.angle_out), 0);
      if (i == 8) begin
        chk("str_e5_ang", int'(bus_sc.angle_out), 101);
        chk("str_e5_cos", int'(bus_sc.cos_out), 622);
        chk("str_e5_tang", int'(bus_sc.t_angle_out), 2047);
      end
      if (i == 9) chk("str_hold_ang", int'(bus_sc.angle_out), 101);
      if (i == 10) chk("str_e6_ang", int'(bus_sc.angle_out), 111);
    end

    // Asynchronous reset between edges clears outputs immediately
    #2;
    reset = 1'b0;
    #1;
    chk("arst_sc_cos", int'(bus_sc.cos_out), 0);
    chk("arst_sc_sin", int'(bus_sc.sin_out), 0);
    chk("arst_sc_ang", int'(bus_sc.angle_out), 0);
    chk("arst_sc_tang", int'(bus_sc.t_angle_out), 0);
    chk("arst_s1_cos", int'(bus_s1.cos_out), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
